// File: rtl/icache_if.sv
// Fetcher and memory-controller handshake bundle for the instruction cache.
interface icache_if;
   logic         valid_from_fetcher;
   logic [31:0]  addr_from_fetcher;
   logic         flush_from_rob;
   logic         ready_to_fetcher;
   logic [31:0]  inst_to_fetcher;
   logic         valid_to_mem;
   logic [31:0]  addr_to_mem;
   logic         ready_from_mem;
   logic [127:0] data_from_mem;

   modport master (
      input  valid_from_fetcher,
      input  addr_from_fetcher,
      input  flush_from_rob,
      output ready_to_fetcher,
      output inst_to_fetcher,
      output valid_to_mem,
      output addr_to_mem,
      input  ready_from_mem,
      input  data_from_mem
   );

   modport slave (
      output valid_from_fetcher,
      output addr_from_fetcher,
      output flush_from_rob,
      input  ready_to_fetcher,
      input  inst_to_fetcher,
      input  valid_to_mem,
      input  addr_to_mem,
      output ready_from_mem,
      output data_from_mem
   );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, 16-byte lines.
// Misses fetch a whole line from the memory controller.
module icache #(
   parameter int INDEX_WIDTH = 6
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     rdy,
   icache_if.master bus
);
   localparam int TAG_WIDTH = 32 - 4 - INDEX_WIDTH;
   localparam int NLINES    = 1 << INDEX_WIDTH;

   typedef enum logic {IDLE, MISS} state_t;

   state_t state_q, state_d;

   logic [NLINES-1:0]    valid_q;
   logic [TAG_WIDTH-1:0] tag_q  [NLINES];
   logic [127:0]         data_q [NLINES];

   logic                   discard_q, discard_d;
   logic                   ready_q, ready_d;
   logic [31:0]            inst_q, inst_d;
   logic                   vmem_q, vmem_d;
   logic [31:0]            amem_q, amem_d;
   logic [INDEX_WIDTH-1:0] midx_q, midx_d;
   logic [TAG_WIDTH-1:0]   mtag_q, mtag_d;
   logic [1:0]             mwsel_q, mwsel_d;
   logic                   fill;

   logic [INDEX_WIDTH-1:0] a_idx;
   logic [TAG_WIDTH-1:0]   a_tag;
   logic [1:0]             a_wsel;
   logic [127:0]           a_line;
   logic                   hit;
   logic                   unused_ok;

   assign a_idx     = bus.addr_from_fetcher[4+INDEX_WIDTH-1:4];
   assign a_tag     = bus.addr_from_fetcher[31:4+INDEX_WIDTH];
   assign a_wsel    = bus.addr_from_fetcher[3:2];
   assign a_line    = data_q[a_idx];
   assign hit       = valid_q[a_idx] && (tag_q[a_idx] == a_tag);
   assign unused_ok = ^bus.addr_from_fetcher[1:0];

   always_comb begin
      state_d   = state_q;
      discard_d = discard_q;
      ready_d   = 1'b0;
      inst_d    = inst_q;
      vmem_d    = vmem_q;
      amem_d    = amem_q;
      midx_d    = midx_q;
      mtag_d    = mtag_q;
      mwsel_d   = mwsel_q;
      fill      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!bus.flush_from_rob && bus.valid_from_fetcher
                && !ready_q) begin
               if (hit) begin
                  ready_d = 1'b1;
                  inst_d  = a_line[{a_wsel, 5'b0} +: 32];
               end else begin
                  amem_d  = {a_tag, a_idx, 4'b0};
                  vmem_d  = 1'b1;
                  midx_d  = a_idx;
                  mtag_d  = a_tag;
                  mwsel_d = a_wsel;
                  state_d = MISS;
               end
            end
         end
         MISS: begin
            // the request stays up even when flushed; the burst may be in flight
            if (bus.flush_from_rob) discard_d = 1'b1;
            if (bus.ready_from_mem) begin
               vmem_d = 1'b0;
               fill   = 1'b1;
               if (!discard_q && !bus.flush_from_rob) begin
                  ready_d = 1'b1;
                  inst_d  = bus.data_from_mem[{mwsel_q, 5'b0} +: 32];
               end
               discard_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         valid_q   <= '0;
         discard_q <= 1'b0;
         ready_q   <= 1'b0;
         inst_q    <= '0;
         vmem_q    <= 1'b0;
         amem_q    <= '0;
         midx_q    <= '0;
         mtag_q    <= '0;
         mwsel_q   <= '0;
      end else if (rdy) begin
         state_q   <= state_d;
         discard_q <= discard_d;
         ready_q   <= ready_d;
         inst_q    <= inst_d;
         vmem_q    <= vmem_d;
         amem_q    <= amem_d;
         midx_q    <= midx_d;
         mtag_q    <= mtag_d;
         mwsel_q   <= mwsel_d;
         if (fill) valid_q[midx_q] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rdy && fill) begin
         tag_q[midx_q]  <= mtag_q;
         data_q[midx_q] <= bus.data_from_mem;
      end
   end

   assign bus.ready_to_fetcher = ready_q;
   assign bus.inst_to_fetcher  = inst_q;
   assign bus.valid_to_mem     = vmem_q;
   assign bus.addr_to_mem      = amem_q;
endmodule
